// File: rtl/gshare_pht.sv
// gshare pattern history table: 2-bit saturating counters indexed by PC^GHR,
// with an in-order in-flight queue that pairs each prediction with its resolve.

module gshare_ctr #(
  parameter logic [1:0] CNT_RST = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= CNT_RST;
    else if (upd) begin
      if (taken) begin
        if (cnt != 2'b11) cnt <= cnt + 2'd1;
      end else begin
        if (cnt != 2'b00) cnt <= cnt - 2'd1;
      end
    end
  end
endmodule

module gshare_pht #(
  parameter int         IDX_W   = 4,
  parameter int         QDEPTH  = 4,
  parameter logic [1:0] CNT_RST = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lookup_valid,
  input  logic [IDX_W-1:0]          lookup_index,
  output logic                      pred_valid,
  output logic                      pred_taken,
  input  logic                      resolve_valid,
  input  logic                      resolve_taken,
  output logic                      mispredict,
  output logic                      resolve_err,
  input  logic                      flush,
  output logic                      q_full,
  output logic [$clog2(QDEPTH):0]   q_count
);
  localparam int NENT  = 1 << IDX_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } q_ent_t;

  q_ent_t                q_mem [QDEPTH];
  logic [NENT-1:0][1:0]  cnt;
  logic [NENT-1:0]       upd;
  logic [PTR_W-1:0]      head, tail;
  logic                  q_empty, lk_acc, rs_acc, rd_msb;
  q_ent_t                head_ent;

  assign q_full   = (q_count == CNT_W'(QDEPTH));
  assign q_empty  = (q_count == '0);
  assign lk_acc   = lookup_valid & ~q_full & ~flush;
  assign rs_acc   = resolve_valid & ~q_empty;
  assign head_ent = q_mem[head];
  // Counters are registers, so this read sees the pre-train value on a same-cycle resolve.
  assign rd_msb   = cnt[lookup_index][1];

  for (genvar g = 0; g < NENT; g++) begin : g_ctr
    assign upd[g] = rs_acc && (head_ent.idx == IDX_W'(g));
    gshare_ctr #(.CNT_RST(CNT_RST)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .upd   (upd[g]),
      .taken (resolve_taken),
      .cnt   (cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (lk_acc) q_mem[tail] <= '{idx: lookup_index, pred: rd_msb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else if (flush) begin
      // Lookups are never accepted under flush, so tail is already final.
      head    <= tail;
      q_count <= '0;
    end else begin
      if (lk_acc) tail <= tail + PTR_W'(1);
      if (rs_acc) head <= head + PTR_W'(1);
      case ({lk_acc, rs_acc})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      pred_valid  <= lk_acc;
      if (lk_acc) pred_taken <= rd_msb;
      mispredict  <= rs_acc & (resolve_taken ^ head_ent.pred);
      resolve_err <= resolve_valid & q_empty;
    end
  end
endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed vector table plus randomized traffic, all
// checked against a queue/array model of the predictor.

module tb_gshare_pht;
  localparam int IDX_W = 4;
  localparam int QD    = 4;
  localparam int NENT  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             lookup_valid, resolve_valid, resolve_taken, flush;
  logic [IDX_W-1:0] lookup_index;
  logic             pred_valid, pred_taken, mispredict, resolve_err, q_full;
  logic [2:0]       q_count;

  gshare_pht #(.IDX_W(IDX_W), .QDEPTH(QD), .CNT_RST(2'b01)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_valid  (lookup_valid),
    .lookup_index  (lookup_index),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .mispredict    (mispredict),
    .resolve_err   (resolve_err),
    .flush         (flush),
    .q_full        (q_full),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit pred; } ent_t;
  typedef struct {
    bit lv; int li; bit rv; bit rt; bit fl;
    bit pv; bit pt; bit mis; bit err; int cnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pht [NENT];
  ent_t mq [$];
  bit   m_pt;
  vec_t tbl [$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pht[i]) pht[i] = 1;
    mq.delete();
    m_pt = 0;
  endtask

  task automatic chk_table(string nm);
    int bad = -1;
    for (int i = NENT - 1; i >= 0; i--)
      if (int'(dut.cnt[i]) != pht[i]) bad = i;
    chk(nm, bad, -1);
  endtask

  // One clock: drive, check combinational status, clock, update model, check outputs.
  task automatic step(bit lv, int li, bit rv, bit rt, bit fl);
    bit lk, rs, mis, err;
    int c;
    ent_t e;
    lookup_valid  = lv;
    lookup_index  = 4'(li);
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
    #1;
    chk("q_full_pre", q_full, mq.size() == QD);
    chk("q_count_pre", q_count, mq.size());
    @(posedge clk);
    lk  = lv && (mq.size() < QD) && !fl;
    rs  = rv && (mq.size() != 0);
    err = rv && (mq.size() == 0);
    c   = pht[li];
    mis = 0;
    if (rs) begin
      e = mq.pop_front();
      mis = (rt != e.pred);
      if (rt) pht[e.idx] = (pht[e.idx] < 3) ? pht[e.idx] + 1 : 3;
      else    pht[e.idx] = (pht[e.idx] > 0) ? pht[e.idx] - 1 : 0;
    end
    if (lk) begin
      mq.push_back('{idx: li, pred: (c >= 2)});
      m_pt = (c >= 2);
    end
    if (fl) mq.delete();
    #1;
    chk("pred_valid", pred_valid, lk);
    chk("pred_taken", pred_taken, m_pt);
    chk("mispredict", mispredict, mis);
    chk("resolve_err", resolve_err, err);
    chk("q_count", q_count, mq.size());
    chk_table("pht_table");
  endtask

  task automatic add(bit lv, int li, bit rv, bit rt, bit fl,
                     bit pv, bit pt, bit mis, bit err, int cnt);
    tbl.push_back('{lv, li, rv, rt, fl, pv, pt, mis, err, cnt});
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_pred_valid"}, pred_valid, 0);
    chk({tag, "_pred_taken"}, pred_taken, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_resolve_err"}, resolve_err, 0);
  endtask

  initial begin
    //   lv li rv rt fl | pv pt mis err cnt
    add(1, 5, 0, 0, 0,  1, 0, 0, 0, 1);   // weak NT predicts 0
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 0);   // taken -> mispredict, pht5=2
    add(1, 5, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0);   // pht5=3
    add(1, 9, 0, 0, 0,  1, 0, 0, 0, 1);   // idx 9 training: 1->2->3->3->3
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 0);
    add(1, 9, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0);
    add(1, 9, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0);
    add(1, 9, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0);
    add(1, 9, 0, 0, 0,  1, 1, 0, 0, 1);   // then not-taken: 3->2->1->0->0
    add(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
    add(1, 9, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0,  0, 1, 1, 0, 0);
    add(1, 9, 0, 0, 0,  1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1, 9, 0, 0, 0,  1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);   // saturates at 0
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 1);   // fill the queue
    add(1, 1, 0, 0, 0,  1, 0, 0, 0, 2);
    add(1, 2, 0, 0, 0,  1, 0, 0, 0, 3);
    add(1, 3, 0, 0, 0,  1, 0, 0, 0, 4);
    add(1, 4, 0, 0, 0,  0, 0, 0, 0, 4);   // rejected while full
    add(1, 6, 1, 1, 0,  0, 0, 1, 0, 3);   // full: lookup rejected, pop proceeds
    add(0, 0, 1, 0, 0,  0, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0,  1, 0, 0, 0, 1);
    add(1, 7, 1, 1, 0,  1, 0, 1, 0, 1);   // same idx: lookup sees pre-update 1
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 0);   // pht7 2->3
    add(1, 7, 0, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0);
    add(1, 10, 0, 0, 0, 1, 0, 0, 0, 1);   // three queued, then resolve+flush
    add(1, 11, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 12, 0, 0, 0, 1, 0, 0, 0, 3);
    add(1, 13, 1, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 0, 1, 0);   // resolve on empty queue
    add(1, 10, 0, 0, 0, 1, 1, 0, 0, 1);   // flush kept the training
    add(1, 11, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 10, 1, 1, 0, 1, 1, 0, 0, 2);   // two queued, counters trained

    lookup_valid = 0; lookup_index = '0; resolve_valid = 0;
    resolve_taken = 0; flush = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_q_full", q_full, 0);
    chk_table("reset_pht");
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].lv, tbl[i].li, tbl[i].rv, tbl[i].rt, tbl[i].fl);
      chk($sformatf("tbl%0d_pv", i), pred_valid, tbl[i].pv);
      chk($sformatf("tbl%0d_pt", i), pred_taken, tbl[i].pt);
      chk($sformatf("tbl%0d_mis", i), mispredict, tbl[i].mis);
      chk($sformatf("tbl%0d_err", i), resolve_err, tbl[i].err);
      chk($sformatf("tbl%0d_cnt", i), q_count, tbl[i].cnt);
    end

    // Asynchronous reset mid-operation, away from any clock edge.
    lookup_valid = 0; resolve_valid = 0; flush = 0;
    rst = 1'b1;
    #1;
    model_reset();
    chk_idle_outputs("midrst");
    chk_table("midrst_pht");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 10, 0, 0, 0);
    chk("post_rst_pt10", pred_taken, 0);
    step(1, 5, 0, 0, 0);
    chk("post_rst_pt5", pred_taken, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    for (int n = 0; n < 400; n++)
      step($urandom_range(99) < 70, $urandom_range(NENT - 1),
           $urandom_range(99) < 45, $urandom_range(1),
           $urandom_range(99) < 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
